sanduba_front: RTL and testbench

SANDUBA_FRONT -- requirements
Module: sanduba_front

---
 rtl/sanduba_pkg.sv | 21 ++
 rtl/sanduba_debounce.sv | 48 ++++
 rtl/sanduba_front.sv | 107 ++++++++++
 tb/tb_sanduba_front.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sanduba_pkg.sv
// Shared types and defaults for the sandwich-machine front end.
package sanduba_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Request vector bit order is {dev, r_green, r_atum, r_bacon}.
  typedef logic [3:0] req_t;

  localparam int REQ_DEV   = 3;
  localparam int REQ_GREEN = 2;
  localparam int REQ_ATUM  = 1;
  localparam int REQ_BACON = 0;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_COIN_PEND_MAX   = 3;

endpackage

// File: rtl/sanduba_debounce.sv
// One raw input: 2-flop synchronizer, debounce counter, rising-edge event.
module sanduba_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic event_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, prev_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // The counter tracks how many consecutive samples disagree with the level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      prev_q <= level_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign event_o = level_q & ~prev_q;

endmodule

// File: rtl/sanduba_front.sv
// Front end: debounced coin/button events queued and issued one selection at a time.
module sanduba_front
  import sanduba_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int COIN_PEND_MAX   = DEFAULT_COIN_PEND_MAX
) (
  input  logic clock,
  input  logic reset,
  input  logic coin_raw,
  input  logic btn_dev_raw,
  input  logic btn_green_raw,
  input  logic btn_atum_raw,
  input  logic btn_bacon_raw,
  input  logic busy,
  output logic m100,
  output logic dev,
  output logic r_green,
  output logic r_atum,
  output logic r_bacon,
  output logic coin_reject
);

  localparam int PEND_W = $clog2(COIN_PEND_MAX + 1);

  logic              coin_ev;
  req_t              btn_raw, btn_ev;
  state_e            state_q;
  logic              sel_coin_q;
  req_t              sel_req_q;
  logic [PEND_W-1:0] pend_q, pend_d;
  req_t              req_q, req_d;
  logic              issue, coin_inc, coin_dec;

  assign btn_raw = {btn_dev_raw, btn_green_raw, btn_atum_raw, btn_bacon_raw};

  sanduba_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin_db (
    .clock  (clock),
    .reset  (reset),
    .raw_i  (coin_raw),
    .event_o(coin_ev)
  );

  for (genvar b = 0; b < 4; b++) begin : g_btn
    sanduba_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (btn_raw[b]),
      .event_o(btn_ev[b])
    );
  end

  assign issue = (state_q == ISSUE) && !busy;

  // A coin arriving while full is only kept if a coin leaves in the same cycle.
  always_comb begin
    coin_dec = issue && sel_coin_q;
    coin_inc = coin_ev && ((pend_q != PEND_W'(COIN_PEND_MAX)) || coin_dec);
    pend_d   = pend_q;
    if (coin_inc && !coin_dec) begin
      pend_d = pend_q + 1'b1;
    end else if (!coin_inc && coin_dec) begin
      pend_d = pend_q - 1'b1;
    end
    req_d = (issue ? (req_q & ~sel_req_q) : req_q) | btn_ev;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_q <= '0;
      req_q  <= '0;
    end else begin
      pend_q <= pend_d;
      req_q  <= req_d;
    end
  end

  // Coins win the selection so that a refund request already sees all credit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_coin_q <= 1'b0;
      sel_req_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!busy && ((pend_q != '0) || (req_q != '0))) begin
            state_q    <= ISSUE;
            sel_coin_q <= (pend_q != '0);
            sel_req_q  <= (pend_q != '0) ? '0 : req_q;
          end
        end
        ISSUE:   state_q <= busy ? IDLE : HOLD;
        HOLD:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m100        = issue && sel_coin_q;
  assign dev         = issue && sel_req_q[REQ_DEV];
  assign r_green     = issue && sel_req_q[REQ_GREEN];
  assign r_atum      = issue && sel_req_q[REQ_ATUM];
  assign r_bacon     = issue && sel_req_q[REQ_BACON];
  assign coin_reject = (pend_q == PEND_W'(COIN_PEND_MAX));

endmodule

// File: tb/tb_sanduba_front.sv
// Randomised and directed bench for sanduba_front against a behavioural model.
module tb_sanduba_front;

  localparam int D    = 4;
  localparam int MAXP = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic coin_raw = 1'b0, btn_dev_raw = 1'b0, btn_green_raw = 1'b0;
  logic btn_atum_raw = 1'b0, btn_bacon_raw = 1'b0, busy = 1'b0;
  logic m100, dev, r_green, r_atum, r_bacon, coin_reject;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sanduba_front #(.DEBOUNCE_CYCLES(D), .COIN_PEND_MAX(MAXP)) dut (
    .clock        (clock),
    .reset        (reset),
    .coin_raw     (coin_raw),
    .btn_dev_raw  (btn_dev_raw),
    .btn_green_raw(btn_green_raw),
    .btn_atum_raw (btn_atum_raw),
    .btn_bacon_raw(btn_bacon_raw),
    .busy         (busy),
    .m100         (m100),
    .dev          (dev),
    .r_green      (r_green),
    .r_atum       (r_atum),
    .r_bacon      (r_bacon),
    .coin_reject  (coin_reject)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Model: input i is accepted once its last D synchronized samples all oppose the level.
  int        mPend = 0;
  int        mPhase = 0;
  bit        mSelCoin = 1'b0;
  bit [3:0]  mSelReq = 4'b0, mReq = 4'b0;
  bit        s1[5], s2[5], lvl[5], prv[5];
  int unsigned hist[5];

  always @(posedge clock or posedge reset) begin : modelStep
    bit          ev[5];
    bit          rawNow[5];
    bit          issued, coinOut;
    int          oldPend;
    bit [3:0]    oldReq, evReq;
    int unsigned mask, win;
    if (reset) begin
      mPend = 0; mPhase = 0; mSelCoin = 1'b0; mSelReq = 4'b0; mReq = 4'b0;
      for (int i = 0; i < 5; i++) begin
        s1[i] = 1'b0; s2[i] = 1'b0; lvl[i] = 1'b0; prv[i] = 1'b0; hist[i] = 0;
      end
    end else begin
      rawNow[0] = coin_raw;  rawNow[1] = btn_dev_raw; rawNow[2] = btn_green_raw;
      rawNow[3] = btn_atum_raw; rawNow[4] = btn_bacon_raw;
      for (int i = 0; i < 5; i++) ev[i] = lvl[i] && !prv[i];
      evReq   = {ev[1], ev[2], ev[3], ev[4]};
      issued  = (mPhase == 1) && !busy;
      coinOut = issued && mSelCoin;
      oldPend = mPend;
      oldReq  = mReq;
      if (ev[0] && !coinOut) begin
        if (mPend < MAXP) mPend = mPend + 1;
      end else if (!ev[0] && coinOut) begin
        mPend = mPend - 1;
      end
      mReq = (issued ? (mReq & ~mSelReq) : mReq) | evReq;
      if (mPhase == 0) begin
        if (!busy && (oldPend > 0 || oldReq != 0)) begin
          mPhase   = 1;
          mSelCoin = (oldPend > 0);
          mSelReq  = (oldPend > 0) ? 4'b0 : oldReq;
        end
      end else if (mPhase == 1) begin
        mPhase = busy ? 0 : 2;
      end else begin
        mPhase = 0;
      end
      mask = (32'd1 << D) - 32'd1;
      for (int i = 0; i < 5; i++) begin
        hist[i] = (hist[i] << 1) | {31'd0, s2[i]};
        prv[i]  = lvl[i];
        win     = hist[i] & mask;
        if ((lvl[i] && win == 0) || (!lvl[i] && win == mask)) lvl[i] = !lvl[i];
        s2[i] = s1[i];
        s1[i] = rawNow[i];
      end
    end
  end

  int edgeCount = 0;
  int m100Pulses = 0, reqPulses = 0, pairPulses = 0, devPulses = 0;
  int m100Edges[$];
  int seq[$];

  always @(posedge clock) edgeCount++;

  // Compare every cycle, then log pulses for the directed checks.
  always @(negedge clock) begin : compareStep
    bit       expIssue;
    bit [5:0] expVec;
    expIssue = (mPhase == 1) && !busy;
    expVec   = {expIssue && mSelCoin, expIssue ? mSelReq : 4'b0, mPend == MAXP};
    checkOutput("outputs", {26'd0, m100, dev, r_green, r_atum, r_bacon, coin_reject}, {26'd0, expVec});
    if (m100) begin
      m100Pulses++;
      m100Edges.push_back(edgeCount);
      seq.push_back(1);
    end
    if (dev | r_green | r_atum | r_bacon) begin
      reqPulses++;
      seq.push_back(16 + int'({dev, r_green, r_atum, r_bacon}));
    end
    if (dev) devPulses++;
    if (r_green && r_bacon) pairPulses++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input int which, input int highCycles, input int lowCycles);
    case (which)
      0: coin_raw = 1'b1;
      1: btn_dev_raw = 1'b1;
      default: begin btn_green_raw = 1'b1; btn_bacon_raw = 1'b1; end
    endcase
    tick(highCycles);
    coin_raw = 1'b0; btn_dev_raw = 1'b0; btn_green_raw = 1'b0; btn_bacon_raw = 1'b0;
    tick(lowCycles);
  endtask

  initial begin
    int s, e0, r0, minGap, sq;
    @(negedge clock);
    checkOutput("reset_m100", {31'd0, m100}, 32'd0);
    checkOutput("reset_reject", {31'd0, coin_reject}, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(3);

    // Single long coin: one pulse, D+4 edges after the first sampled high.
    s = m100Edges.size(); r0 = reqPulses; e0 = edgeCount;
    coin_raw = 1'b1;
    tick(10);
    coin_raw = 1'b0;
    tick(20);
    checkOutput("coin_pulses", m100Edges.size() - s, 1);
    checkOutput("coin_no_req", reqPulses - r0, 0);
    if (m100Edges.size() > s) checkOutput("coin_latency", m100Edges[s] - e0, D + 4);

    // Glitch shorter than the debounce window.
    s = m100Pulses;
    applyStimulus(0, 3, 15);
    checkOutput("glitch_pulses", m100Pulses - s, 0);
    checkOutput("glitch_reject", {31'd0, coin_reject}, 32'd0);

    // Queue fills while busy; the fourth coin is dropped.
    busy = 1'b1;
    applyStimulus(0, 6, 8);
    applyStimulus(0, 6, 8);
    checkOutput("two_coins_reject", {31'd0, coin_reject}, 32'd0);
    applyStimulus(0, 6, 8);
    checkOutput("full_reject", {31'd0, coin_reject}, 32'd1);
    applyStimulus(0, 6, 8);
    checkOutput("drop_reject", {31'd0, coin_reject}, 32'd1);
    s = m100Edges.size();
    busy = 1'b0;
    tick(25);
    checkOutput("drain_pulses", m100Edges.size() - s, 3);
    minGap = 1000;
    for (int i = s + 1; i < m100Edges.size(); i++)
      if (m100Edges[i] - m100Edges[i-1] < minGap) minGap = m100Edges[i] - m100Edges[i-1];
    checkOutput("drain_gap_ok", {31'd0, minGap >= 2}, 32'd1);
    checkOutput("drain_reject", {31'd0, coin_reject}, 32'd0);

    // Two buttons together come out together, once.
    s = pairPulses; r0 = reqPulses;
    applyStimulus(2, 10, 15);
    checkOutput("pair_pulses", pairPulses - s, 1);
    checkOutput("pair_req_cycles", reqPulses - r0, 1);

    // Coins are issued ahead of a pending refund.
    busy = 1'b1;
    applyStimulus(0, 6, 8);
    applyStimulus(0, 6, 8);
    applyStimulus(1, 8, 8);
    sq = seq.size();
    busy = 1'b0;
    tick(25);
    checkOutput("order_len", seq.size() - sq, 3);
    if (seq.size() - sq == 3) begin
      checkOutput("order_0", seq[sq], 1);
      checkOutput("order_1", seq[sq+1], 1);
      checkOutput("order_2", seq[sq+2], 16 + 8);
    end

    // Busy rising in the issue cycle defers the coin.
    busy = 1'b1;
    applyStimulus(0, 6, 8);
    s = m100Pulses;
    busy = 1'b0;
    tick(1);
    busy = 1'b1;
    tick(6);
    checkOutput("deferred_none", m100Pulses - s, 0);
    busy = 1'b0;
    tick(10);
    checkOutput("deferred_once", m100Pulses - s, 1);

    // Reset discards pending coins.
    busy = 1'b1;
    applyStimulus(0, 6, 8);
    applyStimulus(0, 6, 8);
    s = m100Pulses;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    busy = 1'b0;
    tick(20);
    checkOutput("reset_discard", m100Pulses - s, 0);

    // Button held across reset release yields one event.
    s = devPulses;
    btn_dev_raw = 1'b1;
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(20);
    btn_dev_raw = 1'b0;
    tick(15);
    checkOutput("held_through_reset", devPulses - s, 1);

    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0)  coin_raw      = ~coin_raw;
      if ($urandom_range(0, 14) == 0) btn_dev_raw   = ~btn_dev_raw;
      if ($urandom_range(0, 14) == 0) btn_green_raw = ~btn_green_raw;
      if ($urandom_range(0, 14) == 0) btn_atum_raw  = ~btn_atum_raw;
      if ($urandom_range(0, 14) == 0) btn_bacon_raw = ~btn_bacon_raw;
      if ($urandom_range(0, 4) == 0)  busy          = ~busy;
      reset = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 1'b0;
    tick(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
